ifns_link_scheduler: RTL and testbench
======================================

Name: ifns_link_scheduler

Overview:
- Shares one IFNS 22-bit-to-31-bit crosstalk-avoidance encoder and its registered TSV codeword bus among NUM_REQ requesters.
- Arbitration is round-robin with burst locking. The granted 22-bit word goes through one instance of encoderIFNS_22di_core.
- The codeword is registered onto the link with a valid/ready handshake and a requester-ID sideband.
- When idle, the bus holds its last codeword, so there are no spurious TSV transitions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive words granted to one requester before the grant must rotate (1..15).
- ID_W, 2, width of requester ID. Must equal ceil(log2(NUM_REQ)); checked at elaboration.

Ports:
- clock  in  1  single clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  22*NUM_REQ  per-requester data word; slice i = bits [22*i+21 : 22*i].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- codeout  out  31  registered IFNS codeword; bit 31 is MSB, bit 1 is LSB.
- code_valid  out  1  codeout holds an unconsumed word.
- code_ready  in  1  link accepts codeout this cycle.
- code_id  out  ID_W  requester index of the current codeout.
- word_count  out  16  total words accepted since reset; wraps modulo 2^16.

Behaviour:
- Reset (async assert, released synchronously by the environment) clears everything:
  - codeout=0, code_valid=0, code_id=0, word_count=0.
  - rr_ptr=0, owner=0, burst_cnt=0, state=ARB.
- Output slot is free when code_valid=0 or code_ready=1.
- Grant: exactly one candidate c is computed combinationally each cycle (see FSM).
  - req_ready[c]=1 only if req_valid[c]=1 and the slot is free; all other req_ready bits are 0.
  - req_ready never depends on req_ready; there is no combinational loop from code_ready beyond the slot-free term.
- Accept: a word is accepted when req_valid[c] and req_ready[c] are both 1. On the next edge:
  - codeout <= encode(req_data[c]); code_id <= c; code_valid <= 1; word_count increments.
  - Latency from accept to code_valid is 1 cycle.
- No accept but code_ready=1: code_valid <= 0 and codeout/code_id hold their value. The bus never returns to 0 when idle.
- Back-to-back accepts are allowed, giving one word per cycle when code_ready is held at 1.
- code_valid=1 and code_ready=0: codeout, code_id and code_valid are all stable (link stall). No requester is accepted.
- FSM state ARB:
  - c is the first requester with req_valid=1 scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On accept: owner <= c, burst_cnt <= 1. Go to LOCK if MAX_BURST > 1; otherwise stay in ARB with rr_ptr <= c+1.
- FSM state LOCK: c = owner.
  - Accept while burst_cnt < MAX_BURST-1: burst_cnt increments, stay in LOCK.
  - Accept when burst_cnt = MAX_BURST-1: go to ARB, rr_ptr <= owner+1 (mod NUM_REQ), burst_cnt <= 0.
  - req_valid[owner]=0 with the slot free: go to ARB, rr_ptr <= owner+1, no accept this cycle. The bubble is accepted.
  - Slot not free (stall): hold state and burst_cnt; the lock survives stalls.
- Encode uses encoderIFNS_22di_core, which is combinational, between the grant mux and the codeout register. There are no other pipeline stages.
- Boundary conditions:
  - No requester valid in ARB: no accept, rr_ptr unchanged.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - word_count wraps from 0xFFFF to 0x0000.
  - req_valid dropping while stalled is a protocol violation by the requester; the bench asserts against it.
  - Reset asserted mid-burst or mid-stall returns to reset values immediately. Any unconsumed codeout is discarded.

Decomposition:
- Shared package ifns_pkg holds:
  - IFNS_DATA_W=22, IFNS_CODE_W=31.
  - The FSM state enum {ARB, LOCK}.
  - A function that computes the next round-robin index.
- One sub-module: ifns_rr_arbiter. It is combinational and produces the candidate index plus a found flag from req_valid and rr_ptr.
- The encoder core is instantiated as is. The FSM, counters and output register live in the top module.

Test Plan:
- Reset check: assert rst mid-traffic -> same cycle codeout=0, code_valid=0, word_count=0; first accept after release comes from requester 0.
- Single requester: NUM_REQ=4, req_valid=4'b0100, code_ready=1, 6 words -> code_id=2 each time; codeout matches a golden encoder model 1 cycle after each accept.
- Burst lock: all 4 requesters always valid, MAX_BURST=4, code_ready=1 -> ids 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; word_count=17.
- Early release: requester 1 valid for 2 words only, others valid -> ids 1,1, then a 1-cycle bubble, then 2,2,2,2.
- Stall: code_ready=0 for 5 cycles while code_valid=1 -> codeout/code_id stable, req_ready=0; on release, burst continues with burst_cnt preserved.
- Idle hold and wrap: after the last word, deassert all valids -> codeout keeps its last value and code_valid drops; preload 65535 accepts -> word_count reads 0x0000 after the next accept.

Source files
------------

// File: rtl/ifns_pkg.sv
// Shared widths, FSM state type and helper functions for the IFNS link scheduler.
package ifns_pkg;

  localparam int IFNS_DATA_W = 22;
  localparam int IFNS_CODE_W = 31;

  typedef enum logic {ARB, LOCK} state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Weight of codeword bit k (1..30) is the Fibonacci number F(k+1), with F(1)=F(2)=1.
  function automatic logic [IFNS_DATA_W-2:0] fib_weight(input int k);
    int unsigned a, b, t;
    a = 1;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (IFNS_DATA_W-1)'(a);
  endfunction

endpackage

// File: rtl/encoderIFNS_22di_core.sv
// Combinational IFNS encoder: data MSB drives code bit 31, the low 21 bits become a Zeckendorf word on bits 30..1.
module encoderIFNS_22di_core
  import ifns_pkg::*;
(
  input  logic [IFNS_DATA_W-1:0] data_in,
  output logic [IFNS_CODE_W:1]   code_out
);

  always_comb begin
    logic [IFNS_DATA_W-2:0] rem;
    code_out              = '0;
    code_out[IFNS_CODE_W] = data_in[IFNS_DATA_W-1];
    rem                   = data_in[IFNS_DATA_W-2:0];
    // Greedy subtraction from the largest weight never sets two adjacent bits, which keeps the TSV bus crosstalk-safe.
    for (int k = IFNS_CODE_W - 1; k >= 1; k--) begin
      if (rem >= fib_weight(k)) begin
        code_out[k] = 1'b1;
        rem         = rem - fib_weight(k);
      end
    end
  end

endmodule

// File: rtl/ifns_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module ifns_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               found
);

  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
    idx   = '0;
    grant = '0;
    found = 1'b0;
    // Walk the rotation backwards so the requester closest to rr_ptr is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ));
      if (valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifns_link_scheduler.sv
// Round-robin, burst-locking scheduler that shares one IFNS encoder and its registered TSV codeword bus.
module ifns_link_scheduler
  import ifns_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = 2
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [IFNS_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [IFNS_CODE_W:1]           codeout,
  output logic                           code_valid,
  input  logic                           code_ready,
  output logic [ID_W-1:0]                code_id,
  output logic [15:0]                    word_count
);

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..15");
  end

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [3:0]             burst_q, burst_d;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_found;
  logic [ID_W-1:0]        cand;
  logic                   slot_free;
  logic                   accept;
  logic [IFNS_DATA_W-1:0] req_word [NUM_REQ];
  logic [IFNS_CODE_W:1]   enc_code;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[IFNS_DATA_W*i +: IFNS_DATA_W];
  end

  ifns_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_idx),
    .found  (arb_found)
  );

  // The slot-free term is the only path from code_ready into req_ready.
  assign slot_free = !code_valid || code_ready;
  assign cand      = (state_q == LOCK) ? owner_q : arb_idx;
  assign accept    = slot_free && ((state_q == LOCK) ? req_valid[owner_q] : arb_found);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[cand] = 1'b1;
  end

  encoderIFNS_22di_core u_enc (
    .data_in  (req_word[cand]),
    .code_out (enc_code)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    case (state_q)
      ARB: begin
        if (accept) begin
          owner_d = cand;
          burst_d = 4'd1;
          if (MAX_BURST > 1) state_d = LOCK;
          else rr_ptr_d = ID_W'(rr_next(32'(cand), NUM_REQ));
        end
      end
      LOCK: begin
        // A stalled slot leaves the lock and its count untouched.
        if (slot_free) begin
          if (accept && burst_q < 4'(MAX_BURST - 1)) begin
            burst_d = burst_q + 4'd1;
          end else begin
            state_d  = ARB;
            rr_ptr_d = ID_W'(rr_next(32'(owner_q), NUM_REQ));
            burst_d  = '0;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
    end
  end

  // Without an accept the bus keeps its last codeword so an idle link never toggles.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      codeout    <= '0;
      code_valid <= 1'b0;
      code_id    <= '0;
      word_count <= '0;
    end else if (accept) begin
      codeout    <= enc_code;
      code_id    <= cand;
      code_valid <= 1'b1;
      word_count <= word_count + 16'd1;
    end else if (code_ready) begin
      code_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifns_link_scheduler.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_ifns_link_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;

  logic         clock = 1'b0;
  logic         rst   = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [87:0]  req_data  = '0;
  logic [3:0]   req_ready;
  logic [31:1]  codeout;
  logic         code_valid;
  logic         code_ready = 1'b0;
  logic [1:0]   code_id;
  logic [15:0]  word_count;

  always #5 clock = ~clock;

  ifns_link_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST),
    .ID_W      (ID_W)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .codeout    (codeout),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_id    (code_id),
    .word_count (word_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a lock is "owner plus words still allowed", not a state machine.
  int          m_ptr;
  int          m_owner;
  int          m_left;
  logic        m_valid;
  int          m_id;
  logic [15:0] m_count;
  logic [21:0] m_word;

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_left = 0;
    m_valid = 1'b0; m_id = 0; m_count = '0; m_word = '0;
  endtask

  // Value carried by a codeword: bit 31 is worth 2^21, bit k (1..30) is worth F(k+1).
  function automatic int unsigned decode(input logic [31:1] cw);
    int unsigned f_prev, f_cur, t, sum;
    f_prev = 1; f_cur = 1; sum = 0;
    for (int k = 1; k <= 30; k++) begin
      if (cw[k]) sum += f_cur;
      t = f_prev + f_cur;
      f_prev = f_cur;
      f_cur = t;
    end
    if (cw[31]) sum += 32'd1 << 21;
    return sum;
  endfunction

  function automatic logic has_adjacent(input logic [31:1] cw);
    for (int k = 1; k < 30; k++) if (cw[k] && cw[k+1]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive at posedge+1, check req_ready at negedge, check registers at the next posedge+1.
  task automatic drive(input logic [3:0] v, input logic cr, output logic [3:0] rdy_seen);
    int c;
    logic sf, acc;
    logic [3:0] exp_rdy;
    req_valid  = v;
    code_ready = cr;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*22 +: 22] = 22'($urandom);
    sf = !m_valid || cr;
    if (m_owner >= 0) c = m_owner;
    else begin
      c = m_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (v[(m_ptr + k) % NUM_REQ]) begin
          c = (m_ptr + k) % NUM_REQ;
          break;
        end
      end
    end
    acc     = v[c] && sf;
    exp_rdy = acc ? 4'(1 << c) : 4'b0000;
    @(negedge clock);
    rdy_seen = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (acc) begin
      m_word = req_data[c*22 +: 22];
      m_id = c;
      m_valid = 1'b1;
      m_count = m_count + 16'd1;
      if (m_owner < 0) begin
        if (MAX_BURST > 1) begin
          m_owner = c;
          m_left = MAX_BURST - 1;
        end else m_ptr = (c + 1) % NUM_REQ;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_ptr = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end
      end
    end else begin
      if (sf && m_owner >= 0 && !v[m_owner]) begin
        m_ptr = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end
      if (cr) m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    check("code_valid", 32'(code_valid), 32'(m_valid));
    check("code_id", 32'(code_id), 32'(m_id));
    check("word_count", 32'(word_count), 32'(m_count));
    check("codeout_value", decode(codeout), 32'(m_word));
    check("codeout_form", 32'(has_adjacent(codeout)), 32'd0);
  endtask

  // Called at posedge+1; reset takes effect asynchronously and is released one edge later.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_codeout", {1'b0, codeout}, 32'd0);
    check("rst_code_valid", 32'(code_valid), 32'd0);
    check("rst_code_id", 32'(code_id), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    req_valid  = '0;
    code_ready = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  // Requesters must hold req_valid through a stall; this guards the bench's own stimulus.
  logic [3:0] mon_v = '0;
  logic       mon_stall = 1'b0;
  always @(negedge clock) begin
    if (rst) mon_stall = 1'b0;
    else begin
      assert (!(mon_stall && ((mon_v & ~req_valid) != 4'b0000)))
        else $error("FAIL protocol: req_valid dropped during stall, was %b now %b", mon_v, req_valid);
      mon_stall = code_valid && !code_ready;
      mon_v     = req_valid;
    end
  end

  typedef struct {
    logic        do_rst;
    logic [3:0]  valid;
    logic        cr;
    logic [3:0]  exp_ready;
    logic        exp_cv;
    logic [1:0]  exp_id;
    logic [15:0] exp_cnt;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    int          burst_ids[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    int          resume_ids[3] = '{0, 0, 1};
    logic [3:0]  rdy;
    logic [31:1] saved;
    logic [3:0]  v, last_v;
    logic        cr, last_stall, this_stall;

    // Burst lock with everyone valid, then early release of requester 1 after two words.
    for (int i = 0; i < 17; i++)
      vecs.push_back(vec_t'{(i == 0), 4'b1111, 1'b1, 4'(1 << burst_ids[i]), 1'b1, 2'(burst_ids[i]), 16'(i + 1)});
    vecs.push_back(vec_t'{1'b1, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'd1});
    vecs.push_back(vec_t'{1'b0, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'd2});
    vecs.push_back(vec_t'{1'b0, 4'b1100, 1'b1, 4'b0000, 1'b0, 2'd1, 16'd2});
    vecs.push_back(vec_t'{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd3});
    vecs.push_back(vec_t'{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd4});
    vecs.push_back(vec_t'{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd5});
    vecs.push_back(vec_t'{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd6});
    vecs.push_back(vec_t'{1'b0, 4'b1100, 1'b1, 4'b1000, 1'b1, 2'd3, 16'd7});

    model_reset();
    @(posedge clock);
    #1;

    foreach (vecs[n]) begin
      if (vecs[n].do_rst) do_reset();
      drive(vecs[n].valid, vecs[n].cr, rdy);
      check($sformatf("vec%0d_ready", n), 32'(rdy), 32'(vecs[n].exp_ready));
      check($sformatf("vec%0d_valid", n), 32'(code_valid), 32'(vecs[n].exp_cv));
      check($sformatf("vec%0d_id", n), 32'(code_id), 32'(vecs[n].exp_id));
      check($sformatf("vec%0d_count", n), 32'(word_count), 32'(vecs[n].exp_cnt));
    end

    // Stall mid-burst: bus frozen, nobody accepted, burst count survives.
    do_reset();
    drive(4'b1111, 1'b1, rdy);
    drive(4'b1111, 1'b1, rdy);
    check("stall_pre_id", 32'(code_id), 32'd0);
    saved = codeout;
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b0, rdy);
      check("stall_ready", 32'(rdy), 32'd0);
      check("stall_codeout", {1'b0, codeout}, {1'b0, saved});
      check("stall_id", 32'(code_id), 32'd0);
      check("stall_valid", 32'(code_valid), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b1, rdy);
      check("resume_id", 32'(code_id), 32'(resume_ids[i]));
    end
    check("resume_count", 32'(word_count), 32'd5);

    // Idle: bus holds its last codeword while code_valid drops.
    saved = codeout;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1, rdy);
      check("idle_codeout", {1'b0, codeout}, {1'b0, saved});
      check("idle_valid", 32'(code_valid), 32'd0);
    end

    // Reset in the middle of a locked, stalled burst owned by requester 2.
    drive(4'b1111, 1'b1, rdy);
    drive(4'b1111, 1'b1, rdy);
    check("pre_rst_id", 32'(code_id), 32'd2);
    drive(4'b1111, 1'b0, rdy);
    do_reset();
    drive(4'b1111, 1'b1, rdy);
    check("post_rst_id", 32'(code_id), 32'd0);
    check("post_rst_count", 32'(word_count), 32'd1);

    // word_count wrap.
    do_reset();
    for (int i = 0; i < 65535; i++) drive(4'b0001, 1'b1, rdy);
    check("wrap_pre", 32'(word_count), 32'h0000_ffff);
    drive(4'b0001, 1'b1, rdy);
    check("wrap_post", 32'(word_count), 32'd0);

    // Randomized traffic and back-pressure against the model.
    do_reset();
    last_v = '0;
    last_stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      v  = 4'($urandom);
      cr = ($urandom_range(0, 3) != 0);
      if (last_stall) v = v | last_v;
      this_stall = m_valid && !cr;
      drive(v, cr, rdy);
      last_v = v;
      last_stall = this_stall;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
